// File: rtl/traffic_light_monitor.sv
// Passive phase decoder and order/length checker for the traffic_light lamp outputs.
// Optional length checking is compiled in when TL_MON_LEN_CHECK_EN is defined.
//
// state        | meaning
// SYNC         | waiting for a 100 pattern to align to RED, no checking
// RED          | red lamp phase (100), or gap after it
// YELLOW_RED   | red+yellow phase (110), or gap after it
// GREEN        | steady green phase (001), or gap after it
// BLINKY_GREEN | green blinking (001/000 alternating) until 010
// YELLOW       | yellow phase (010), or gap after it
module traffic_light_monitor #(
  parameter int unsigned PERIOD_RED          = 3,
  parameter int unsigned PERIOD_YELLOW_RED   = 3,
  parameter int unsigned PERIOD_GREEN        = 3,
  parameter int unsigned PERIOD_BLINKY_GREEN = 3,
  parameter int unsigned PERIOD_YELLOW       = 3,
  parameter int unsigned TOL                 = 1,
  parameter int unsigned GAP_MAX             = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        red_i,
  input  logic        yellow_i,
  input  logic        green_i,
  input  logic        clr_i,
  output logic [2:0]  phase_o,
  output logic        phase_done_o,
  output logic [7:0]  phase_len_o,
  output logic        error_o,
  output logic [1:0]  err_code_o,
  output logic [15:0] cycle_cnt_o
);

  typedef enum logic [2:0] {
    ST_SYNC       = 3'd0,
    ST_RED        = 3'd1,
    ST_YELLOW_RED = 3'd2,
    ST_GREEN      = 3'd3,
    ST_BLINKY     = 3'd4,
    ST_YELLOW     = 3'd5
  } phase_e;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_PATTERN = 2'd1;
  localparam logic [1:0] ERR_SEQ     = 2'd2;
  localparam logic [1:0] ERR_LEN     = 2'd3;

  localparam logic [2:0] PAT_DARK  = 3'b000;
  localparam logic [2:0] PAT_RED   = 3'b100;
  localparam logic [2:0] PAT_GREEN = 3'b001;
  localparam logic [2:0] PAT_YEL   = 3'b010;

  function automatic logic [2:0] own_pat(input phase_e p);
    case (p)
      ST_RED:        own_pat = 3'b100;
      ST_YELLOW_RED: own_pat = 3'b110;
      ST_GREEN:      own_pat = 3'b001;
      ST_BLINKY:     own_pat = 3'b001;
      ST_YELLOW:     own_pat = 3'b010;
      default:       own_pat = 3'b111;
    endcase
  endfunction

  function automatic phase_e succ_of(input phase_e p);
    case (p)
      ST_RED:        succ_of = ST_YELLOW_RED;
      ST_YELLOW_RED: succ_of = ST_GREEN;
      ST_GREEN:      succ_of = ST_BLINKY;
      ST_BLINKY:     succ_of = ST_YELLOW;
      ST_YELLOW:     succ_of = ST_RED;
      default:       succ_of = ST_SYNC;
    endcase
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    sat_inc = (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  phase_e     phase_q, phase_n, phase_d;
  logic       in_gap_q, in_gap_n, in_gap_d;
  logic [7:0] len_q, len_n, len_d;
  logic [7:0] gap_q, gap_n, gap_d;
  logic       done_d;
  logic [7:0] plen_d;
  logic       err_d;
  logic [1:0] code_d;
  logic [15:0] cyc_d;

  logic [2:0] pat;
  logic       illegal;
  logic       complete;
  logic [7:0] comp_len;
  logic       seq_err;
  logic       len_err;
  logic       cyc_inc;
  logic [7:0] gap_inc;
  logic [7:0] gap_dark;
  logic [8:0] blink_sum;
  phase_e     succ;
  logic [1:0] new_err;

  assign pat     = {red_i, yellow_i, green_i};
  assign illegal = (pat == 3'b111) || (pat == 3'b101) || (pat == 3'b011);
  assign succ    = succ_of(phase_q);
  assign gap_inc = sat_inc(gap_q);

  // Phase tracking and order checks, before error resolution.
  always_comb begin
    phase_n   = phase_q;
    in_gap_n  = in_gap_q;
    len_n     = len_q;
    gap_n     = gap_q;
    complete  = 1'b0;
    comp_len  = len_q;
    seq_err   = 1'b0;
    cyc_inc   = 1'b0;
    gap_dark  = in_gap_q ? gap_inc : 8'd1;
    blink_sum = {1'b0, len_q} + {1'b0, gap_q} + 9'd1;
    case (phase_q)
      ST_SYNC: begin
        if (pat == PAT_RED) begin
          phase_n  = ST_RED;
          len_n    = 8'd1;
          gap_n    = 8'd0;
          in_gap_n = 1'b0;
        end
      end
      // Blink darks are folded into the length only once a later 001 proves
      // they were internal; trailing darks before 010 are the inter-phase gap.
      ST_BLINKY: begin
        if (illegal) begin
        end else if (pat == PAT_DARK) begin
          gap_n = gap_inc;
          if (32'(gap_inc) > GAP_MAX + 1) seq_err = 1'b1;
        end else if (pat == PAT_GREEN) begin
          if (gap_q == 8'd0) begin
            seq_err = 1'b1;
          end else begin
            len_n = blink_sum[8] ? 8'hFF : blink_sum[7:0];
            gap_n = 8'd0;
          end
        end else if (pat == PAT_YEL) begin
          complete = 1'b1;
          phase_n  = ST_YELLOW;
          len_n    = 8'd1;
          gap_n    = 8'd0;
          in_gap_n = 1'b0;
        end else begin
          seq_err = 1'b1;
        end
      end
      default: begin
        if (illegal) begin
        end else if (pat == PAT_DARK) begin
          complete = !in_gap_q;
          in_gap_n = 1'b1;
          gap_n    = gap_dark;
          if (32'(gap_dark) > GAP_MAX) seq_err = 1'b1;
        end else if (!in_gap_q && pat == own_pat(phase_q)) begin
          len_n = sat_inc(len_q);
        end else if (pat == own_pat(succ) && (in_gap_q || phase_q != ST_GREEN)) begin
          complete = !in_gap_q;
          phase_n  = succ;
          len_n    = 8'd1;
          gap_n    = 8'd0;
          in_gap_n = 1'b0;
          cyc_inc  = (phase_q == ST_YELLOW);
        end else begin
          seq_err = 1'b1;
        end
      end
    endcase
  end

`ifdef TL_MON_LEN_CHECK_EN
  logic [31:0] exp_len;
  always_comb begin
    case (phase_q)
      ST_RED:        exp_len = PERIOD_RED;
      ST_YELLOW_RED: exp_len = PERIOD_YELLOW_RED;
      ST_GREEN:      exp_len = PERIOD_GREEN;
      ST_BLINKY:     exp_len = PERIOD_BLINKY_GREEN;
      ST_YELLOW:     exp_len = PERIOD_YELLOW;
      default:       exp_len = 32'd0;
    endcase
    len_err = complete &&
              ((32'(comp_len) > exp_len + TOL) || (32'(comp_len) + TOL < exp_len));
  end
`else
  localparam int unsigned unused_len_params = PERIOD_RED + PERIOD_YELLOW_RED + PERIOD_GREEN +
                                              PERIOD_BLINKY_GREEN + PERIOD_YELLOW + TOL;
  assign len_err = 1'b0;
`endif

  // Error resolution: a new error always wins over clr_i, and only the first code is kept.
  always_comb begin
    phase_d  = phase_n;
    in_gap_d = in_gap_n;
    len_d    = len_n;
    gap_d    = gap_n;
    done_d   = 1'b0;
    plen_d   = phase_len_o;
    err_d    = error_o;
    code_d   = err_code_o;
    cyc_d    = cycle_cnt_o;
    if (illegal && phase_q != ST_SYNC) new_err = ERR_PATTERN;
    else if (seq_err)                  new_err = ERR_SEQ;
    else if (len_err)                  new_err = ERR_LEN;
    else                               new_err = ERR_NONE;
    // Gating on the current pulse keeps phase_done_o from ever holding two cycles.
    if (complete && !clr_i) begin
      done_d = !phase_done_o;
      plen_d = comp_len;
    end
    if (new_err != ERR_NONE) begin
      err_d    = 1'b1;
      if (clr_i || err_code_o == ERR_NONE) code_d = new_err;
      phase_d  = ST_SYNC;
      in_gap_d = 1'b0;
      len_d    = 8'd0;
      gap_d    = 8'd0;
    end else if (clr_i) begin
      err_d    = 1'b0;
      code_d   = ERR_NONE;
      phase_d  = ST_SYNC;
      in_gap_d = 1'b0;
      len_d    = 8'd0;
      gap_d    = 8'd0;
    end else if (cyc_inc) begin
      cyc_d = cycle_cnt_o + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      phase_q      <= ST_SYNC;
      in_gap_q     <= 1'b0;
      len_q        <= 8'd0;
      gap_q        <= 8'd0;
      phase_done_o <= 1'b0;
      phase_len_o  <= 8'd0;
      error_o      <= 1'b0;
      err_code_o   <= ERR_NONE;
      cycle_cnt_o  <= 16'd0;
    end else begin
      phase_q      <= phase_d;
      in_gap_q     <= in_gap_d;
      len_q        <= len_d;
      gap_q        <= gap_d;
      phase_done_o <= done_d;
      phase_len_o  <= plen_d;
      error_o      <= err_d;
      err_code_o   <= code_d;
      cycle_cnt_o  <= cyc_d;
    end
  end

  assign phase_o = phase_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Scoreboard bench for traffic_light_monitor: expected done lengths and error
// events are queued with the stimulus and checked by an independent monitor.
module tb_traffic_light_monitor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        red = 1'b0, yellow = 1'b0, green = 1'b0, clr = 1'b0;
  logic [2:0]  phase;
  logic        done;
  logic [7:0]  plen;
  logic        err;
  logic [1:0]  code;
  logic [15:0] cyc;

  traffic_light_monitor #(
    .PERIOD_RED(3), .PERIOD_YELLOW_RED(3), .PERIOD_GREEN(3),
    .PERIOD_BLINKY_GREEN(3), .PERIOD_YELLOW(3), .TOL(1), .GAP_MAX(1)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .red_i(red), .yellow_i(yellow), .green_i(green), .clr_i(clr),
    .phase_o(phase), .phase_done_o(done), .phase_len_o(plen),
    .error_o(err), .err_code_o(code), .cycle_cnt_o(cyc)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_len_q[$];
  int exp_err_q[$];   // {error, code} packed as error*4 + code
  int prev_err = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Monitor: pops an expectation whenever the DUT presents a done pulse or an error change.
  always @(negedge clk) begin
    int cur;
    cur = int'(err) * 4 + int'(code);
    if (rst_n) begin
      if (done) begin
        if (exp_len_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_done: got len %0d, want no pulse", plen);
        end else begin
          check("done_len", int'(plen), exp_len_q.pop_front());
        end
      end
      if (cur != prev_err) begin
        if (exp_err_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_err_event: got err/code %0d, want no change", cur);
        end else begin
          check("err_event", cur, exp_err_q.pop_front());
        end
      end
    end
    prev_err = cur;
  end

  task automatic drive(input logic [2:0] p, input int n, input logic c);
    for (int i = 0; i < n; i++) begin
      {red, yellow, green} = p;
      clr = c;
      @(posedge clk);
      #1;
    end
    clr = 1'b0;
  endtask

  // RED, YELLOW_RED, GREEN each of length 3 with single dark gaps; ends in GREEN gap.
  task automatic run_to_green_gap();
    repeat (3) exp_len_q.push_back(3);
    drive(3'b100, 3, 1'b0); drive(3'b000, 1, 1'b0);
    drive(3'b110, 3, 1'b0); drive(3'b000, 1, 1'b0);
    drive(3'b001, 3, 1'b0); drive(3'b000, 1, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish before timeout");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_phase", int'(phase), 0);
    check("rst_done", int'(done), 0);
    check("rst_len", int'(plen), 0);
    check("rst_err", int'(err), 0);
    check("rst_code", int'(code), 0);
    check("rst_cyc", int'(cyc), 0);
    rst_n = 1'b1;

    // Clean full cycle
    run_to_green_gap();
    exp_len_q.push_back(3);   // BLINKY_GREEN: 001,000,001
    exp_len_q.push_back(3);   // YELLOW
    drive(3'b001, 1, 1'b0);
    check("blink_phase", int'(phase), 4);
    drive(3'b000, 1, 1'b0); drive(3'b001, 1, 1'b0);
    drive(3'b000, 1, 1'b0);
    drive(3'b010, 3, 1'b0); drive(3'b000, 1, 1'b0);
    drive(3'b100, 1, 1'b0);
    check("clean_phase", int'(phase), 1);
    check("clean_cyc", int'(cyc), 1);
    check("clean_err", int'(err), 0);

    // Illegal pattern in GREEN, then a second illegal keeps code 1
    exp_len_q.push_back(3); exp_len_q.push_back(3);
    drive(3'b100, 2, 1'b0); drive(3'b000, 1, 1'b0);
    drive(3'b110, 3, 1'b0); drive(3'b000, 1, 1'b0);
    drive(3'b001, 2, 1'b0);
    exp_err_q.push_back(4 + 1);
    drive(3'b101, 1, 1'b0);
    check("illegal_err", int'(err), 1);
    check("illegal_code", int'(code), 1);
    check("illegal_phase", int'(phase), 0);
    drive(3'b100, 1, 1'b0);
    drive(3'b011, 1, 1'b0);
    check("illegal2_code", int'(code), 1);
    check("illegal2_phase", int'(phase), 0);
    check("illegal_cyc", int'(cyc), 1);

    // Sequence violation, then clr together with an illegal pattern
    exp_err_q.push_back(0);
    drive(3'b000, 1, 1'b1);
    exp_err_q.push_back(4 + 2);
    drive(3'b100, 2, 1'b0);
    drive(3'b001, 1, 1'b0);
    check("seq_code", int'(code), 2);
    drive(3'b100, 1, 1'b0);
    exp_err_q.push_back(4 + 1);
    drive(3'b111, 1, 1'b1);
    check("clr_new_err", int'(err), 1);
    check("clr_new_code", int'(code), 1);
    exp_err_q.push_back(0);
    drive(3'b000, 1, 1'b1);

    // Length violation: RED held 6 clocks
    exp_len_q.push_back(6);
`ifdef TL_MON_LEN_CHECK_EN
    exp_err_q.push_back(4 + 3);
`endif
    drive(3'b100, 6, 1'b0); drive(3'b000, 1, 1'b0);
`ifdef TL_MON_LEN_CHECK_EN
    check("len_phase", int'(phase), 0);
    check("len_code", int'(code), 3);
    exp_err_q.push_back(0);
`else
    check("len_phase", int'(phase), 1);
    check("len_code", int'(code), 0);
`endif
    drive(3'b110, 1, 1'b1);
    check("len_clr_phase", int'(phase), 0);

    // Gap overrun after YELLOW_RED
    exp_len_q.push_back(3); exp_len_q.push_back(3);
    drive(3'b100, 3, 1'b0); drive(3'b000, 1, 1'b0);
    drive(3'b110, 3, 1'b0); drive(3'b000, 1, 1'b0);
    exp_err_q.push_back(4 + 2);
    drive(3'b000, 1, 1'b0);
    check("gap_code", int'(code), 2);
    exp_err_q.push_back(0);
    drive(3'b000, 1, 1'b1);

    // 001 held for two cycles inside BLINKY_GREEN
    run_to_green_gap();
    drive(3'b001, 1, 1'b0);
    exp_err_q.push_back(4 + 2);
    drive(3'b001, 1, 1'b0);
    check("blink_hold_code", int'(code), 2);
    exp_err_q.push_back(0);
    drive(3'b000, 1, 1'b1);

    // Asynchronous reset mid-BLINKY_GREEN
    run_to_green_gap();
    drive(3'b001, 1, 1'b0); drive(3'b000, 1, 1'b0);
    check("pre_rst_phase", int'(phase), 4);
    rst_n = 1'b0;
    #1;
    check("arst_phase", int'(phase), 0);
    check("arst_len", int'(plen), 0);
    check("arst_cyc", int'(cyc), 0);
    check("arst_err", int'(err), 0);
    check("arst_done", int'(done), 0);
    rst_n = 1'b1;
    drive(3'b010, 2, 1'b0);
    check("post_rst_phase", int'(phase), 0);
    check("post_rst_err", int'(err), 0);
    drive(3'b100, 1, 1'b0);
    check("fresh_red_phase", int'(phase), 1);
    check("fresh_red_cyc", int'(cyc), 0);

    @(negedge clk);
    @(negedge clk);
    check("len_queue_drained", exp_len_q.size(), 0);
    check("err_queue_drained", exp_err_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/traffic_light_monitor.md
# traffic_light_monitor

Passive checker/decoder on the lamp outputs of the `traffic_light` controller. It samples `red`/`yellow`/`green` every clock and reconstructs the current phase. It checks the phase order and phase lengths, and reports the first violation as a sticky error. It sits beside the controller in the intersection top and in benches, and its phase outputs feed the status/logging logic.

## Interface
- `PERIOD_RED`, 3, expected RED length in clocks
- `PERIOD_YELLOW_RED`, 3, expected YELLOW_RED length
- `PERIOD_GREEN`, 3, expected steady GREEN length
- `PERIOD_BLINKY_GREEN`, 3, expected BLINKY_GREEN length
- `PERIOD_YELLOW`, 3, expected YELLOW length
- `TOL`, 1, allowed |measured − expected| in clocks
- `GAP_MAX`, 1, maximum consecutive all-dark cycles between phases
- `clk_i` in 1: clock, rising edge
- `rst_ni` in 1: asynchronous, active-low reset
- `red_i`, `yellow_i`, `green_i` in 1 each: lamp levels, synchronous to `clk_i`
- `clr_i` in 1: clears the sticky error and resynchronises
- `phase_o` out 3: 0 SYNC, 1 RED, 2 YELLOW_RED, 3 GREEN, 4 BLINKY_GREEN, 5 YELLOW
- `phase_done_o` out 1: one-cycle pulse when a phase completes legally
- `phase_len_o` out 8: length of the last completed phase
- `error_o` out 1: sticky error flag
- `err_code_o` out 2: 0 none, 1 illegal pattern, 2 sequence, 3 length; holds the first error
- `cycle_cnt_o` out 16: count of completed full RED→…→YELLOW cycles, wraps

## Operation
- Pattern notation is {red, yellow, green}.
  - Legal non-dark patterns: 100 RED, 110 YELLOW_RED, 001 GREEN/BLINK, 010 YELLOW.
  - Patterns 111, 101 and 011 are illegal and raise code 1 in every state except SYNC.
- **SYNC:** ignore all input and raise no errors. On 100, enter RED with length counter = 1.
- **Normal phase, same pattern:** the length counter increments and saturates at 255.
- **Normal phase, 000:** ends the phase and starts a gap.
  - The gap counter increments each dark cycle.
  - If the gap exceeds `GAP_MAX`, raise code 2.
- **Next non-dark pattern (direct or after a gap)** must be the legal successor:
  - RED → 110
  - YELLOW_RED → 001, entering GREEN
  - GREEN → 001 after a gap, entering BLINKY_GREEN
  - BLINKY_GREEN → 010, entering YELLOW
  - YELLOW → 100, entering RED
  - Any other non-dark pattern raises code 2.
- **BLINKY_GREEN:**
  - Length counts from the first 001, including internal 000s, up to the cycle before 010.
  - 001 held for 2 consecutive cycles raises code 2.
  - 000 held for more than `GAP_MAX`+1 cycles raises code 2.
- **Phase completion** occurs on the edge the phase ends (first dark cycle or direct successor):
  - `phase_len_o` ← length.
  - `phase_done_o` pulses.
  - The length check runs; a failure raises code 3, and `phase_done_o` still pulses.
- A legal YELLOW→RED entry increments `cycle_cnt_o`. The RED entry from SYNC does not.
- **On any error:**
  - `error_o` ← 1.
  - `err_code_o` is latched only if it is currently 0.
  - The state returns to SYNC.
- **`clr_i`:**
  - Clears `error_o` and `err_code_o` and forces SYNC.
  - If a new error is detected in the same cycle, the new error wins: the flag is set and the new code is latched.
- `phase_o` holds the current phase during gaps.

## Timing
- No input register. A pattern sampled at edge k is reflected in `phase_o`, `phase_done_o` and `error_o` after edge k (zero-cycle decode latency).
- Reset values:
  - `phase_o` = 0 (SYNC)
  - `phase_done_o` = 0
  - `phase_len_o` = 0
  - `error_o` = 0
  - `err_code_o` = 0
  - `cycle_cnt_o` = 0
  - internal length and gap counters = 0
- Reset asserted mid-phase returns to SYNC immediately (asynchronously). The next 100 starts a fresh RED.
- All outputs are registered. `phase_done_o` is never high for two consecutive cycles.

## Configuration
- `TL_MON_LEN_CHECK_EN`
  - Defined: length checking against `PERIOD_*` ± `TOL` is active, and code 3 can be reported.
  - Undefined: no length comparison is compiled in and code 3 never occurs. `phase_len_o` and `phase_done_o` are still produced.

## Test plan
- **Clean cycle, defaults, macro defined:** drive 100×3, 000, 110×3, 000, 001×3, 000, then 001/000 alternating for 3 clocks, then 000, 010×3, 000, 100.
  - Expect five `phase_done_o` pulses, each with `phase_len_o`=3.
  - Expect `cycle_cnt_o`=1 and `error_o`=0.
- **Illegal pattern:** in GREEN, drive 101.
  - Expect `error_o`=1, `err_code_o`=1 and `phase_o`=0 on the next cycle.
  - Expect a later 011 to leave `err_code_o` at 1.
- **Sequence violation:** after RED, drive 001.
  - Expect `err_code_o`=2.
  - Then assert `clr_i` together with a 111 input: expect `error_o`=1 and `err_code_o`=1.
- **Length violation:** RED held for 6 clocks (expected 3, `TOL`=1).
  - Expect `phase_len_o`=6, a `phase_done_o` pulse and `err_code_o`=3.
  - With the macro undefined, expect no error.
- **Gap overrun:** 000 held for 2 cycles after YELLOW_RED with `GAP_MAX`=1.
  - Expect `err_code_o`=2.
  - Also hold 001 for 2 cycles inside BLINKY_GREEN: expect `err_code_o`=2.
- **Reset:** pull `rst_ni` low mid-BLINKY_GREEN.
  - Expect all outputs at reset values immediately.
  - Expect 010 input before any 100 to be ignored, with no error.
